// File: rtl/interp_seq_ctrl.sv
// Lookup sequencer: scans an ascending (x,y) point BRAM for the pair bracketing x_search,
// hands the pair to an external interpolator and writes the result. Optional macro INTERP_CLAMP_EN.
module interp_seq_ctrl #(
  parameter int NPTS = 512
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] x_search,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] y_out,
  output logic [9:0]  mem_addr,
  input  logic [15:0] mem_dout,
  output logic        ip_valid,
  input  logic        ip_ready,
  output logic [15:0] ip_x0,
  output logic [15:0] ip_x1,
  output logic [15:0] ip_y0,
  output logic [15:0] ip_y1,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        out_we,
  output logic [9:0]  out_addr,
  output logic [15:0] out_din
);

  typedef enum logic [2:0] {IDLE, SCAN, FETCH_Y, ISSUE, WAIT_RES, WRITE, DONE} state_t;

  localparam logic [8:0]  LAST    = 9'(NPTS - 1);
  localparam logic [15:0] SAT_MAX = 16'd9999;
`ifdef INTERP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  state_t      state_q;
  logic [13:0] xs_q;
  logic [8:0]  k_q;        // index of the x entry currently being read
  logic [1:0]  cnt_q;      // read phase within SCAN / FETCH_Y
  logic        single_q;   // FETCH_Y needs one y only (exact hit or clamp)
  logic [15:0] prev_q;     // x[k-1], lower bracket candidate
  logic        busy_q, done_q, err_q, ip_valid_q, out_we_q;
  logic [13:0] y_out_q;
  logic [9:0]  mem_addr_q, out_addr_q;
  logic [15:0] ip_x0_q, ip_x1_q, ip_y0_q, ip_y1_q, out_din_q;

  logic [15:0] xs_ext;
  logic        x_eq, x_lt;
  assign xs_ext = {2'b00, xs_q};
  assign x_eq   = (xs_ext == mem_dout);
  assign x_lt   = (xs_ext <  mem_dout);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // on the same edge see the pre-edge values, independent of statement order.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      xs_q       <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      single_q   <= 1'b0;
      prev_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ip_valid_q <= 1'b0;
      out_we_q   <= 1'b0;
      y_out_q    <= '0;
      mem_addr_q <= '0;
      out_addr_q <= '0;
      ip_x0_q    <= '0;
      ip_x1_q    <= '0;
      ip_y0_q    <= '0;
      ip_y1_q    <= '0;
      out_din_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      out_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            xs_q       <= x_search;
            k_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            mem_addr_q <= '0;
            state_q    <= SCAN;
          end
        end

        SCAN: begin
          if (cnt_q == 2'd0) begin
            cnt_q <= 2'd1;
          end else begin
            cnt_q <= 2'd0;
            // Exact hit, below the table, or past its end all resolve to y[k].
            if (x_eq || (x_lt && k_q == '0) || (!x_lt && k_q == LAST)) begin
              err_q <= !x_eq;
              if (x_eq || CLAMP) begin
                single_q   <= 1'b1;
                mem_addr_q <= {k_q, 1'b1};
                state_q    <= FETCH_Y;
              end else begin
                y_out_q <= '0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= DONE;
              end
            end else if (x_lt) begin
              single_q   <= 1'b0;
              ip_x0_q    <= prev_q;
              ip_x1_q    <= mem_dout;
              mem_addr_q <= {k_q - 9'd1, 1'b1};
              state_q    <= FETCH_Y;
            end else begin
              prev_q     <= mem_dout;
              k_q        <= k_q + 9'd1;
              mem_addr_q <= {k_q + 9'd1, 1'b0};
            end
          end
        end

        FETCH_Y: begin
          case (cnt_q)
            2'd0: begin
              cnt_q <= 2'd1;
              if (!single_q) mem_addr_q <= mem_addr_q + 10'd2;
            end
            2'd1: begin
              if (single_q) begin
                out_din_q <= mem_dout;
                out_we_q  <= 1'b1;
                cnt_q     <= 2'd0;
                state_q   <= WRITE;
              end else begin
                ip_y0_q <= mem_dout;
                cnt_q   <= 2'd2;
              end
            end
            default: begin
              ip_y1_q    <= mem_dout;
              ip_valid_q <= 1'b1;
              cnt_q      <= 2'd0;
              state_q    <= ISSUE;
            end
          endcase
        end

        ISSUE: begin
          if (ip_ready) begin
            ip_valid_q <= 1'b0;
            state_q    <= WAIT_RES;
          end
        end

        WAIT_RES: begin
          if (res_valid) begin
            out_din_q <= res_data;
            out_we_q  <= 1'b1;
            state_q   <= WRITE;
          end
        end

        WRITE: begin
          out_addr_q <= out_addr_q + 10'd1;
          y_out_q    <= (out_din_q > SAT_MAX) ? SAT_MAX[13:0] : out_din_q[13:0];
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= DONE;
        end

        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign y_out    = y_out_q;
  assign mem_addr = mem_addr_q;
  assign ip_valid = ip_valid_q;
  assign ip_x0    = ip_x0_q;
  assign ip_x1    = ip_x1_q;
  assign ip_y0    = ip_y0_q;
  assign ip_y1    = ip_y1_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_din  = out_din_q;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Self-checking bench for interp_seq_ctrl: BRAM and interpolator models, a table-search
// reference model, and a per-cycle compare process. Honours INTERP_CLAMP_EN.
module tb_interp_seq_ctrl;

  localparam int NPTS = 8;
`ifdef INTERP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] x_search;
  logic        busy, done, err;
  logic [13:0] y_out;
  logic [9:0]  mem_addr;
  logic [15:0] mem_dout;
  logic        ip_valid, ip_ready;
  logic [15:0] ip_x0, ip_x1, ip_y0, ip_y1;
  logic        res_valid;
  logic [15:0] res_data;
  logic        out_we;
  logic [9:0]  out_addr;
  logic [15:0] out_din;

  always #5 clk = ~clk;

  interp_seq_ctrl #(.NPTS(NPTS)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start), .x_search(x_search),
    .busy(busy), .done(done), .err(err), .y_out(y_out),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .ip_valid(ip_valid), .ip_ready(ip_ready),
    .ip_x0(ip_x0), .ip_x1(ip_x1), .ip_y0(ip_y0), .ip_y1(ip_y1),
    .res_valid(res_valid), .res_data(res_data),
    .out_we(out_we), .out_addr(out_addr), .out_din(out_din)
  );

  // Point BRAM with one cycle of read latency.
  logic [15:0] mem [0:1023];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  int tx [0:NPTS-1];
  int ty [0:NPTS-1];

  // Reference: kind 0 = bracket, 1 = exact, 2 = below table, 3 = above table.
  typedef struct {
    int kind;
    int x0, x1, y0, y1, yv;
  } model_t;

  function automatic model_t model(input int xs);
    model_t m;
    m = '{kind: 3, x0: 0, x1: 0, y0: 0, y1: 0, yv: ty[NPTS-1]};
    if (xs < tx[0]) begin
      m.kind = 2;
      m.yv   = ty[0];
      return m;
    end
    for (int i = 0; i < NPTS; i++)
      if (xs == tx[i]) begin
        m.kind = 1;
        m.yv   = ty[i];
        return m;
      end
    for (int i = 0; i < NPTS - 1; i++)
      if (tx[i] < xs && xs < tx[i+1]) begin
        m = '{kind: 0, x0: tx[i], x1: tx[i+1], y0: ty[i], y1: ty[i+1], yv: 0};
        return m;
      end
    return m;
  endfunction

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expectations for the lookup in flight.
  model_t exp_m;
  int     exp_y, exp_wval, exp_waddr;
  bit     exp_err, exp_wr;
  int     n_ipv, n_we, n_done, lat;
  logic [15:0] last_ip_x0, last_ip_x1, last_ip_y0, last_ip_y1, last_din;

  always @(negedge clk) begin
    if (reset) begin
      if (ip_valid) begin
        n_ipv++;
        check("ip_x0", ip_x0, exp_m.x0);
        check("ip_x1", ip_x1, exp_m.x1);
        check("ip_y0", ip_y0, exp_m.y0);
        check("ip_y1", ip_y1, exp_m.y1);
        last_ip_x0 = ip_x0; last_ip_x1 = ip_x1;
        last_ip_y0 = ip_y0; last_ip_y1 = ip_y1;
      end
      if (out_we) begin
        n_we++;
        check("out_addr", out_addr, exp_waddr);
        check("out_din", out_din, exp_wval);
        last_din = out_din;
      end
      if (done) begin
        n_done++;
        check("y_out", y_out, exp_y);
        check("err", err, exp_err);
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic load_table(input int x_base, input int y_base);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < NPTS; i++) begin
      tx[i] = x_base + 100 * i;
      ty[i] = y_base + 50 * i;
      mem[2*i]   = 16'(tx[i]);
      mem[2*i+1] = 16'(ty[i]);
    end
  endtask

  task automatic set_expect(input int xs, input logic [15:0] res);
    exp_m    = model(xs);
    exp_err  = (exp_m.kind >= 2);
    exp_wr   = (exp_m.kind < 2) || CLAMP;
    exp_wval = (exp_m.kind == 0) ? int'(res) : exp_m.yv;
    exp_y    = !exp_wr ? 0 : ((exp_wval > 9999) ? 9999 : exp_wval);
  endtask

  // One lookup; rdly = cycles ip_ready stays low, poke = retrigger start and junk res_valid.
  task automatic do_lookup(input int xs, input int rdly, input logic [15:0] res, input bit poke);
    int cyc, vc;
    bit got, sent;
    set_expect(xs, res);
    n_ipv = 0; n_we = 0; n_done = 0;
    @(negedge clk); start = 1'b1; x_search = 14'(xs);
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0; vc = 0; got = 0; sent = 0;
    while (!got && cyc < 4 * NPTS + 100 + rdly) begin
      @(negedge clk);
      cyc++;
      ip_ready = 1'b0; res_valid = 1'b0; res_data = '0; start = 1'b0;
      if (done) got = 1;
      else if (ip_valid) begin
        if (vc >= rdly) ip_ready = 1'b1;
        else if (poke) begin res_valid = 1'b1; res_data = 16'hDEAD; end
        vc++;
      end else if (vc > 0 && !sent) begin
        res_valid = 1'b1; res_data = res; sent = 1;
      end
      if (poke && cyc == 2) begin start = 1'b1; x_search = 14'd50; end
    end
    lat = cyc + 1;
    check("done_seen", got, 1);
    @(negedge clk);
    ip_ready = 1'b0; res_valid = 1'b0; start = 1'b0;
    check("done_pulses", n_done, 1);
    check("write_count", n_we, exp_wr);
    check("ip_valid_cycles", n_ipv, (exp_m.kind == 0) ? rdly + 1 : 0);
    check("busy_after_done", busy, 0);
    if (exp_wr) exp_waddr = (exp_waddr + 1) % 1024;
    check("out_addr_after", out_addr, exp_waddr);
  endtask

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; x_search = '0;
    ip_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    exp_waddr = 0;
    load_table(0, 0);
    set_expect(0, 0);
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ip_valid", ip_valid, 0);
    check("rst_out_we", out_we, 0);
    check("rst_y_out", y_out, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_din", out_din, 0);
    reset = 1'b1;
    @(negedge clk);

    // Interpolated lookup between (200,100) and (300,150).
    do_lookup(250, 0, 16'd125, 0);
    check("pin_ip_x0", last_ip_x0, 200);
    check("pin_ip_x1", last_ip_x1, 300);
    check("pin_ip_y0", last_ip_y0, 100);
    check("pin_ip_y1", last_ip_y1, 150);
    check("pin_y_out_125", y_out, 125);
    check("pin_out_addr_1", out_addr, 1);

    do_lookup(300, 0, 16'd0, 0);
    check("pin_exact_no_ip", n_ipv, 0);
    check("pin_exact_y_out", y_out, 150);

    // Stalled interpolator, stray start and stray res_valid.
    do_lookup(250, 20, 16'd130, 1);
    check("pin_stall_y_out", y_out, 130);

    do_lookup(150, 0, 16'd12000, 0);
    check("pin_sat_y_out", y_out, 9999);
    check("pin_sat_out_din", last_din, 12000);

    do_lookup(0, 0, 16'd0, 0);
    check("pin_first_exact", y_out, 0);
    do_lookup(700, 0, 16'd0, 0);
    check("pin_last_exact", y_out, 350);
    check("latency_last_exact", lat <= 2 * NPTS + 8, 1);
    do_lookup(650, 3, 16'd333, 0);
    check("pin_last_pair", y_out, 333);
    do_lookup(750, 0, 16'd0, 0);
    check("pin_high_err", err, 1);
    check("pin_high_y", y_out, CLAMP ? 350 : 0);
    check("latency_high_oor", lat <= 2 * NPTS + 8, 1);

    // Table starting at x=100: query below the table, then a query that clears err.
    load_table(100, 50);
    do_lookup(50, 0, 16'd0, 0);
    check("pin_low_err", err, 1);
    check("pin_low_y", y_out, CLAMP ? 50 : 0);
    check("pin_low_writes", n_we, CLAMP ? 1 : 0);
    do_lookup(200, 0, 16'd0, 0);
    check("pin_err_cleared", err, 0);
    check("pin_b_exact_y", y_out, 100);

    // Reset while waiting for the interpolator result.
    load_table(0, 0);
    set_expect(250, 16'd0);
    @(negedge clk); start = 1'b1; x_search = 14'd250;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!ip_valid && w < 200) begin @(negedge clk); w++; end
    check("abort_ip_valid_seen", ip_valid, 1);
    ip_ready = 1'b1;
    @(negedge clk); ip_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_wait", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_ip_valid", ip_valid, 0);
    check("abort_out_we", out_we, 0);
    check("abort_y_out", y_out, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_out_addr", out_addr, 0);
    check("abort_out_din", out_din, 0);
    reset = 1'b1;
    exp_waddr = 0;
    @(negedge clk);

    // 1025 writing lookups from a fresh counter leave out_addr at 1.
    do_lookup(250, 0, 16'd77, 0);
    check("pin_after_reset_y", y_out, 77);
    for (int n = 0; n < 1024; n++) do_lookup(100 * (n % NPTS), 0, 16'd0, 0);
    check("pin_wrap_out_addr", out_addr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
